// File: rtl/mmc_cmd_framer.sv
// mmc_cmd_framer
// Sniffs the MMC CMD line and turns it into whole command/response frames,
// each emitted as a byte stream: one header byte, then the frame MSB first.
//
// Ports:
//   FIFO_clk   system clock (FX2 IFCLK)
//   reset_n    asynchronous active-low reset
//   mmc_clk_s  MMC_CLK, already synchronized to FIFO_clk
//   mmc_cmd_s  MMC_CMD, synchronized with the same delay as mmc_clk_s
//   out_data   stream byte
//   out_valid  out_data holds a byte to transfer
//   out_ready  consumer accepts the byte (FIFO not-full)
//   busy       frame being received or drained
//   drop_err   sticky: a completed frame was discarded because the buffer was busy
//
// Header byte: {1, dir, long, crc_ok, end_ok, dropped_since_last_header, 2'b00}.
module mmc_cmd_framer #(
  parameter bit         SAMPLE_RISING   = 1'b1,
  parameter logic [5:0] LONG_RESP_IDX_A = 6'd2,
  parameter logic [5:0] LONG_RESP_IDX_B = 6'd9,
  parameter logic [5:0] LONG_RESP_IDX_C = 6'd10
) (
  input  logic       FIFO_clk,
  input  logic       reset_n,
  input  logic       mmc_clk_s,
  input  logic       mmc_cmd_s,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       drop_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           clk_d_q, clk_d_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           long_q, long_d;
  logic [134:0]   shift_q, shift_d;
  logic [6:0]     crc_q, crc_d;
  logic [5:0]     last_idx_q, last_idx_d;
  logic [143:0]   buf_q, buf_d;
  logic [4:0]     rem_q, rem_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           drop_err_q, drop_err_d;
  logic           pend_drop_q, pend_drop_d;

  logic           strobe_s;
  logic           bit_s;
  logic [135:0]   shift_nx_s;
  logic [7:0]     cnt_inc_s;
  logic [7:0]     target_s;
  logic           crc_win_s;
  logic [6:0]     crc_base_s;
  logic           crc_ok_s;
  logic [7:0]     hdr_s;
  logic           long_idx_s;
  logic           xfer_s;
  logic           done_s;

  // Serial CRC7 step, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  // Next-state logic: bit receive FSM, CRC, frame hand-off and output buffer.
  always_comb begin
    strobe_s   = SAMPLE_RISING ? (!clk_d_q && mmc_clk_s) : (clk_d_q && !mmc_clk_s);
    bit_s      = mmc_cmd_s;
    shift_nx_s = {shift_q, bit_s};
    cnt_inc_s  = cnt_q + 8'd1;
    target_s   = long_q ? 8'd136 : 8'd48;
    // Long frames exclude their first byte from the CRC, so the CRC restarts at bit index 8.
    crc_win_s  = long_q ? ((cnt_q >= 8'd8) && (cnt_q < 8'd128)) : (cnt_q < 8'd40);
    crc_base_s = (long_q && (cnt_q == 8'd8)) ? 7'd0 : crc_q;
    crc_ok_s   = (crc_q == shift_nx_s[7:1]);
    hdr_s      = {1'b1, dir_q, long_q, crc_ok_s, shift_nx_s[0], pend_drop_q, 2'b00};
    long_idx_s = (last_idx_q == LONG_RESP_IDX_A) || (last_idx_q == LONG_RESP_IDX_B) ||
                 (last_idx_q == LONG_RESP_IDX_C);
    xfer_s     = out_valid_q && out_ready;

    clk_d_d     = mmc_clk_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    long_d      = long_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    last_idx_d  = last_idx_q;
    drop_err_d  = drop_err_q;
    pend_drop_d = pend_drop_q;
    done_s      = 1'b0;

    if (strobe_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_s) begin
            state_d = ST_HDR;
            shift_d = shift_nx_s[134:0];
            cnt_d   = 8'd1;
            long_d  = 1'b0;
            crc_d   = crc7_step(7'd0, bit_s);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HDR: begin
          state_d = ST_BODY;
          shift_d = shift_nx_s[134:0];
          cnt_d   = cnt_inc_s;
          dir_d   = bit_s;
          long_d  = !bit_s && long_idx_s;
          crc_d   = crc7_step(crc_q, bit_s);
        end
        ST_BODY: begin
          shift_d = shift_nx_s[134:0];
          cnt_d   = cnt_inc_s;
          if (crc_win_s) begin
            crc_d = crc7_step(crc_base_s, bit_s);
          end else begin
            crc_d = crc_q;
          end
          // Completion is handled in the strobe cycle of the final bit.
          if (cnt_inc_s == target_s) begin
            done_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BODY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (xfer_s) begin
      buf_d = {buf_q[135:0], 8'h00};
      rem_d = rem_q - 5'd1;
    end else begin
      buf_d = buf_q;
      rem_d = rem_q;
    end

    if (done_s) begin
      if (dir_q) begin
        last_idx_d = shift_nx_s[45:40];
      end else begin
        last_idx_d = last_idx_q;
      end
      // A frame may load into an empty buffer, or into one whose final byte leaves this cycle.
      if (!out_valid_q || (xfer_s && (rem_q == 5'd1))) begin
        pend_drop_d = 1'b0;
        if (long_q) begin
          buf_d = {hdr_s, shift_nx_s};
          rem_d = 5'd18;
        end else begin
          buf_d = {hdr_s, shift_nx_s[47:0], 88'd0};
          rem_d = 5'd7;
        end
      end else begin
        drop_err_d  = 1'b1;
        pend_drop_d = 1'b1;
      end
    end else begin
      last_idx_d = last_idx_q;
    end

    out_valid_d = (rem_d != 5'd0);
    busy_d      = (state_d != ST_IDLE) || out_valid_d;
  end

  // State and output registers.
  always_ff @(posedge FIFO_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      clk_d_q     <= 1'b0;
      cnt_q       <= 8'd0;
      dir_q       <= 1'b0;
      long_q      <= 1'b0;
      shift_q     <= '0;
      crc_q       <= 7'd0;
      last_idx_q  <= 6'd63;
      buf_q       <= '0;
      rem_q       <= 5'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_err_q  <= 1'b0;
      pend_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_d_q     <= clk_d_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      long_q      <= long_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      last_idx_q  <= last_idx_d;
      buf_q       <= buf_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      drop_err_q  <= drop_err_d;
      pend_drop_q <= pend_drop_d;
    end
  end

  assign out_data  = buf_q[143:136];
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_mmc_cmd_framer.sv
// Self-checking bench for mmc_cmd_framer: directed scenarios plus randomized
// command/response traffic checked against a byte-level frame model.
module tb_mmc_cmd_framer;

  logic       FIFO_clk = 1'b0;
  logic       reset_n;
  logic       mmc_clk_s;
  logic       mmc_cmd_s;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       drop_err;

  mmc_cmd_framer dut (
    .FIFO_clk (FIFO_clk),
    .reset_n  (reset_n),
    .mmc_clk_s(mmc_clk_s),
    .mmc_cmd_s(mmc_cmd_s),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 FIFO_clk = ~FIFO_clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] frm[18];
  int         frm_n;
  logic [5:0] m_last_cmd;
  bit         m_pend;
  bit         rnd_rdy = 1'b0;
  bit         stall_seen = 1'b0;
  logic [7:0] stall_data;

  always @(posedge FIFO_clk) cyc++;

  // Output monitor: records transferred bytes and checks data stability under back-pressure.
  always @(negedge FIFO_clk) begin
    if (!reset_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid) begin
        total++;
        if (out_data !== stall_data) begin
          bad++;
          $display("FAIL hold_stable: out_data=%02h required=%02h", out_data, stall_data);
        end
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_t.push_back(cyc);
      end
      stall_seen = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] crc7_bytes(input int first, input int last);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = first; i <= last; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = frm[i][b] ^ c[6];
        c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] hdr_of(input bit drop);
    logic lng, ok, eok;
    lng = (frm_n == 17);
    ok  = lng ? (crc7_bytes(1, 15) == frm[16][7:1]) : (crc7_bytes(0, 4) == frm[5][7:1]);
    eok = frm[frm_n-1][0];
    return {1'b1, frm[0][6], lng, ok, eok, drop, 2'b00};
  endfunction

  function automatic int resp_len();
    return (m_last_cmd == 6'd2 || m_last_cmd == 6'd9 || m_last_cmd == 6'd10) ? 17 : 6;
  endfunction

  // Frame in frm[] is emitted: push header and bytes, note command index.
  task automatic model_emit();
    exp_q.push_back(hdr_of(m_pend));
    m_pend = 1'b0;
    for (int i = 0; i < frm_n; i++) exp_q.push_back(frm[i]);
    if (frm[0][6]) m_last_cmd = frm[0][5:0];
  endtask

  // Frame in frm[] completes but is discarded.
  task automatic model_drop();
    m_pend = 1'b1;
    if (frm[0][6]) m_last_cmd = frm[0][5:0];
  endtask

  task automatic mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    frm_n  = 6;
    frm[0] = {2'b01, idx};
    frm[1] = arg[31:24];
    frm[2] = arg[23:16];
    frm[3] = arg[15:8];
    frm[4] = arg[7:0];
    frm[5] = {crc7_bytes(0, 4), 1'b1};
  endtask

  task automatic mk_resp(input int n);
    frm_n = n;
    if (n == 17) begin
      frm[0] = 8'h3F;
      for (int i = 1; i < 16; i++) frm[i] = 8'($urandom);
      frm[16] = {crc7_bytes(1, 15), 1'b1};
    end else begin
      frm[0] = {2'b00, 6'($urandom)};
      for (int i = 1; i < 5; i++) frm[i] = 8'($urandom);
      frm[5] = {crc7_bytes(0, 4), 1'b1};
    end
  endtask

  task automatic mk_lit(input logic [47:0] v);
    frm_n = 6;
    for (int i = 0; i < 6; i++) frm[i] = v[47-8*i -: 8];
  endtask

  // ---------------- stimulus ----------------
  task automatic mmc_bit(input logic b, input int half, input bit rdy_at_rise);
    mmc_clk_s = 1'b0;
    mmc_cmd_s = b;
    for (int k = 0; k < half; k++) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge FIFO_clk); #1;
    end
    mmc_clk_s = 1'b1;
    if (rdy_at_rise) out_ready = 1'b1;
    for (int k = 0; k < half; k++) begin
      if (rnd_rdy && !rdy_at_rise) out_ready = 1'($urandom_range(0, 1));
      @(posedge FIFO_clk); #1;
    end
  endtask

  task automatic send_frame(input int half, input bit rdy_last);
    for (int i = 0; i < frm_n * 8; i++)
      mmc_bit(frm[i/8][7-(i%8)], half, rdy_last && (i == frm_n * 8 - 1));
    mmc_bit(1'b1, half, 1'b0);
    mmc_bit(1'b1, half, 1'b0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mmc_clk_s = 1'b0;
    mmc_cmd_s = 1'b1;
    out_ready = 1'b0;
    rnd_rdy   = 1'b0;
    repeat (3) @(posedge FIFO_clk);
    #1 reset_n = 1'b1;
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    m_last_cmd = 6'd63;
    m_pend     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((out_valid || busy) && k < 3000) begin
      @(posedge FIFO_clk); #1;
      k++;
    end
    if (k >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: out_valid=%0b busy=%0b required idle", name, out_valid, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total += 4;
    if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %02h want 00", out_data); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    if (drop_err !== 1'b0) begin bad++; $display("FAIL rst_drop: got %0b want 0", drop_err); end
  endtask

  task automatic test_cmd0();
    do_reset();
    out_ready = 1'b1;
    mk_lit(48'h40_00_00_00_00_95);
    model_emit();
    send_frame(60, 1'b0);
    wait_idle("cmd0");
    total += 3;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL cmd0_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() < 1 || got_q[0] !== 8'hD8) begin bad++; $display("FAIL cmd0_hdr: got %02h want D8", got_q.size() > 0 ? got_q[0] : 8'h00); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL cmd0_valid_drop: got %0b want 0", out_valid); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL cmd0_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_crc_err();
    do_reset();
    out_ready = 1'b1;
    mk_lit(48'h51_00_00_00_00_57);
    model_emit();
    send_frame(4, 1'b0);
    wait_idle("crcerr");
    total += 2;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL crcerr_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() < 1 || got_q[0] !== 8'hC8) begin bad++; $display("FAIL crcerr_hdr: got %02h want C8", got_q.size() > 0 ? got_q[0] : 8'h00); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL crcerr_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_long_resp();
    do_reset();
    out_ready = 1'b1;
    mk_cmd(6'd9, 32'h1234_0000); model_emit(); send_frame(4, 1'b0);
    mk_resp(resp_len());        model_emit(); send_frame(4, 1'b0);
    mk_cmd(6'd13, 32'h1234_0000); model_emit(); send_frame(4, 1'b0);
    mk_resp(resp_len());        model_emit(); send_frame(4, 1'b0);
    wait_idle("long");
    total += 3;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL long_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() < 8 || got_q[7] !== 8'hB8) begin bad++; $display("FAIL long_hdr: got %02h want B8", got_q.size() > 7 ? got_q[7] : 8'h00); end
    if (got_q.size() < 33 || got_q[32] !== 8'h98) begin bad++; $display("FAIL r1_hdr: got %02h want 98", got_q.size() > 32 ? got_q[32] : 8'h00); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL long_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_drop();
    do_reset();
    out_ready = 1'b0;
    mk_lit(48'h48_00_00_01_AA_87);
    model_emit(); send_frame(4, 1'b0);
    model_drop(); send_frame(4, 1'b0);
    total += 3;
    if (drop_err !== 1'b1) begin bad++; $display("FAIL drop_err_set: got %0b want 1", drop_err); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL drop_hold_valid: got %0b want 1", out_valid); end
    if (out_data !== 8'hD8) begin bad++; $display("FAIL drop_hold_hdr: got %02h want D8", out_data); end
    out_ready = 1'b1;
    wait_idle("drop_drain");
    mk_lit(48'h40_00_00_00_00_95);
    model_emit(); send_frame(4, 1'b0);
    wait_idle("drop");
    total += 4;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL drop_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() < 1 || got_q[0] !== 8'hD8) begin bad++; $display("FAIL drop_first_hdr: got %02h want D8", got_q.size() > 0 ? got_q[0] : 8'h00); end
    if (got_q.size() < 8 || got_q[7] !== 8'hDC) begin bad++; $display("FAIL drop_next_hdr: got %02h want DC", got_q.size() > 7 ? got_q[7] : 8'h00); end
    if (drop_err !== 1'b1) begin bad++; $display("FAIL drop_err_sticky: got %0b want 1", drop_err); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    mk_lit(48'h48_00_00_01_AA_87);
    model_emit(); send_frame(4, 1'b0);
    out_ready = 1'b1;
    repeat (6) @(posedge FIFO_clk);
    #1 out_ready = 1'b0;
    mk_lit(48'h40_00_00_00_00_95);
    model_emit(); send_frame(4, 1'b1);
    wait_idle("b2b");
    total += 4;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() < 8 || got_q[7] !== 8'hD8) begin bad++; $display("FAIL b2b_hdr: got %02h want D8", got_q.size() > 7 ? got_q[7] : 8'h00); end
    if (got_t.size() < 8 || got_t[7] - got_t[6] != 1) begin bad++; $display("FAIL b2b_gap: got %0d cycles want 1", got_t.size() > 7 ? got_t[7] - got_t[6] : -1); end
    if (drop_err !== 1'b0) begin bad++; $display("FAIL b2b_drop: got %0b want 0", drop_err); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    mk_lit(48'h40_00_00_00_00_95);
    for (int i = 0; i < 20; i++) mmc_bit(frm[i/8][7-(i%8)], 4, 1'b0);
    do_reset();
    out_ready = 1'b1;
    repeat (4) mmc_bit(1'b1, 4, 1'b0);
    total += 3;
    if (got_q.size() != 0) begin bad++; $display("FAIL rstmid_out: got %0d bytes want 0", got_q.size()); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
    model_emit(); send_frame(4, 1'b0);
    wait_idle("rstmid");
    total += 2;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (drop_err !== 1'b0) begin bad++; $display("FAIL rstmid_drop: got %0b want 0", drop_err); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] favs [4];
    logic [5:0] idx;
    int         mode;
    favs = '{6'd2, 6'd9, 6'd10, 6'd13};
    do_reset();
    for (int f = 0; f < 12; f++) begin
      if (f % 2 == 0) begin
        idx = $urandom_range(0, 1) ? favs[$urandom_range(0, 3)] : 6'($urandom);
        mk_cmd(idx, $urandom);
      end else begin
        mk_resp(resp_len());
      end
      mode = $urandom_range(0, 3);
      if (mode == 0) frm[frm_n-1] = frm[frm_n-1] ^ 8'h10;
      else if (mode == 1) frm[frm_n-1][0] = 1'b0;
      model_emit();
      rnd_rdy = 1'b1;
      send_frame(4, 1'b0);
      rnd_rdy = 1'b0;
      out_ready = 1'b1;
      wait_idle("rand");
    end
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    mmc_clk_s = 1'b0;
    mmc_cmd_s = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_cmd0();
    test_crc_err();
    test_long_resp();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmc_cmd_framer.md
Name: mmc_cmd_framer

Overview:
- Decodes the sniffed MMC CMD line into whole command and response frames and emits them as a byte stream, one header byte followed by the frame bytes.
- Sits between the MMC input synchronizer and the FX2 FIFO4 write logic, replacing raw bit-shifting with frame-aligned capture.
- Checks CRC7 and the end bit, and tracks the last host command so that 136-bit R2 responses are captured whole.

Parameters:
- SAMPLE_RISING, 1, 1 = sample CMD on the MMC_CLK rising edge; 0 = falling edge.
- LONG_RESP_IDX_A, 2, command index whose response is 136-bit (ALL_SEND_CID).
- LONG_RESP_IDX_B, 9, second such index (SEND_CSD).
- LONG_RESP_IDX_C, 10, third such index (SEND_CID).

Ports:
- FIFO_clk  input  1  system clock (FX2 IFCLK, 48 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- mmc_clk_s  input  1  MMC_CLK, already 2-flop synchronized to FIFO_clk.
- mmc_cmd_s  input  1  MMC_CMD, synchronized with the same delay as mmc_clk_s.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte; this is FIFO4 not-full.
- busy  output  1  a frame is being received or drained; drives the activity LED.
- drop_err  output  1  sticky; set when a frame is dropped. Clears only on reset.

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, drop_err=0. The receive FSM goes to IDLE, last_cmd_idx=63, and the output buffer is empty.
- Edge detect: register mmc_clk_s into clk_d and mmc_cmd_s into cmd_d.
  - The sample strobe fires when clk_d is 0 and mmc_clk_s is 1 (rising), or the inverse if SAMPLE_RISING=0.
  - The sampled bit is mmc_cmd_s in the strobe cycle.
  - There is no other dependency on the MMC clock domain.
- Receive FSM (advances only on a sample strobe):
  - IDLE: bit=0 → HDR. Bit 0 is the start bit; it is shifted in and the bit counter is set to 1.
  - HDR: the next bit is the transmission (dir) bit; shift it in.
    - Target length is 48.
    - If dir=0 and last_cmd_idx equals any LONG_RESP_IDX_*, target length is 136.
    - Go to BODY.
  - BODY: shift bits MSB-first into a 136-bit register and count. When count reaches target length → DONE, handled in the same cycle.
  - DONE: compute flags, hand off to the output buffer, then go to IDLE.
- CRC7: polynomial x^7+x^3+1, initial value 0, updated serially as bits arrive.
  - 48-bit frames: covers bits 47..8; compared against bits 7..1.
  - 136-bit frames: covers bits 127..8; the header byte is excluded.
  - end_ok = last bit is 1.
- last_cmd_idx updates to bits 45..40 only on completion of a dir=1 frame, regardless of crc_ok.
- Header byte:
  - bit7 = 1 (sync marker), bit6 = dir, bit5 = long, bit4 = crc_ok, bit3 = end_ok.
  - bit2 = 1 if at least one frame was dropped since the previous header emitted.
  - bits1:0 = 0.
- Output buffer: one frame deep. It holds the header plus 6 bytes (short frame) or 17 bytes (long frame), frame sent MSB first.
  - Handshake: a byte transfers in a cycle with out_valid=1 and out_ready=1.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - out_valid drops the cycle after the last byte transfers, unless a new frame is loaded that cycle.
- Full handling: if DONE occurs while the buffer is still draining, the new frame is discarded. drop_err and the pending-drop flag are set.
  - Simultaneous case: if DONE and the transfer of the final buffered byte occur in the same cycle, the new frame is loaded, not dropped. out_valid stays 1 with the new header.
- Receive continues into the next frame while the buffer drains; it is never stalled by out_ready.
- busy = (FSM not IDLE) or out_valid.
- Reset mid-frame or mid-drain: everything is discarded and no partial frame is emitted.

Test Plan:
- CMD0 frame 0x40 00 00 00 00 95 clocked at 400 kHz, out_ready=1 → bytes D8 40 00 00 00 00 95, then out_valid=0.
- CMD17 frame 0x51 00 00 00 00 55 with the CRC byte corrupted to 0x57 → header C8 (crc_ok=0, end_ok=1), 6 frame bytes unchanged.
- CMD9 followed by a 136-bit response with a valid content CRC → second header B8 followed by 17 bytes; a 48-bit response after CMD13 → header 98 and 6 bytes.
- Hold out_ready=0 across 2 back-to-back CMD8 frames (0x48 00 00 01 AA 87) → first frame is retained and the second dropped, drop_err=1. Release out_ready: first header is D8, and the next emitted frame's header is DC.
- Assert out_ready on the exact cycle the 7th byte transfers while the next frame completes → no drop, next header D8 emitted on the following cycle.
- Assert reset_n=0 after 20 bits of a frame, then release → no output; the next full CMD0 frame is emitted correctly and drop_err=0.
